// File: rtl/flexbyte_pkg.sv
// Shared types and elaboration helpers for the flexbyte parallel-to-serial stream block.
package flexbyte_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        HELD   = 2'd2
    } pts_state_e;

    function automatic int beats_f(input int num_in, input int num_out);
        if (num_out > 0) begin
            return num_in / num_out;
        end else begin
            return 1;
        end
    endfunction

    function automatic int cnt_w_f(input int beats);
        if (beats > 1) begin
            return $clog2(beats);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/flexbyte_word_buf.sv
// One-word holding register with load/clear and a full flag.
module flexbyte_word_buf #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full
);

    logic [W-1:0] data_r;
    logic         full_r;

    // Holding word and occupancy; clear wins over load.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_r <= {W{1'b0}};
            full_r <= 1'b0;
        end else if (clear) begin
            data_r <= {W{1'b0}};
            full_r <= 1'b0;
        end else if (load) begin
            data_r <= din;
            full_r <= 1'b1;
        end else begin
            data_r <= data_r;
            full_r <= full_r;
        end
    end

    assign dout = data_r;
    assign full = full_r;

endmodule

// File: rtl/flexbyte_pts_stream.sv
// Serialises NUM_BYTES_IN-byte words into NUM_BYTES_OUT-byte beats with a one-word
// holding buffer so back-to-back words stream without a bubble.
module flexbyte_pts_stream
    import flexbyte_pkg::*;
#(
    parameter int NUM_BYTES_IN  = 16,
    parameter int NUM_BYTES_OUT = 8,
    parameter bit MSB_FIRST     = 1'b1
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [8*NUM_BYTES_IN-1:0]  in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [8*NUM_BYTES_OUT-1:0] out_data,
    output logic                       out_first,
    output logic                       out_last
);

    localparam int IN_W  = 8 * NUM_BYTES_IN;
    localparam int OUT_W = 8 * NUM_BYTES_OUT;
    localparam int BEATS = beats_f(NUM_BYTES_IN, NUM_BYTES_OUT);
    localparam int CNT_W = cnt_w_f(BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    if ((NUM_BYTES_OUT < 1) || (NUM_BYTES_IN <= NUM_BYTES_OUT) ||
        ((NUM_BYTES_IN % NUM_BYTES_OUT) != 0)) begin : g_param_check
        $fatal(1, "flexbyte_pts_stream: NUM_BYTES_IN must be a multiple (>1x) of NUM_BYTES_OUT");
    end

    pts_state_e       state_r;
    logic [IN_W-1:0]  sr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [IN_W-1:0]  sr_shift_s;
    logic [IN_W-1:0]  hb_data_s;
    logic             hb_full_s;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             final_beat_s;
    logic             hb_load_s;
    logic             hb_clear_s;

    // Beat order only changes the shift direction and which end of SR is presented.
    if (MSB_FIRST) begin : g_msb
        assign sr_shift_s = sr_r << OUT_W;
        assign out_data   = sr_r[IN_W-1 -: OUT_W];
    end else begin : g_lsb
        assign sr_shift_s = sr_r >> OUT_W;
        assign out_data   = sr_r[OUT_W-1:0];
    end

    assign out_valid    = (state_r != EMPTY);
    assign out_first    = out_valid && (cnt_r == {CNT_W{1'b0}});
    assign out_last     = out_valid && (cnt_r == LAST_CNT);
    assign in_ready     = (state_r != HELD) && !hb_full_s && !flush;
    assign in_xfer_s    = in_valid && in_ready;
    assign out_xfer_s   = out_valid && out_ready && !flush;
    assign final_beat_s = (cnt_r == LAST_CNT);

    // A word parks in HB only when SR is still busy after this edge.
    assign hb_load_s  = (state_r == ACTIVE) && in_xfer_s && !(out_xfer_s && final_beat_s);
    assign hb_clear_s = flush || ((state_r == HELD) && out_xfer_s && final_beat_s);

    flexbyte_word_buf #(.W(IN_W)) u_hold_buf (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (hb_clear_s),
        .load  (hb_load_s),
        .din   (in_data),
        .dout  (hb_data_s),
        .full  (hb_full_s)
    );

    // Stream FSM with shift register and beat counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= EMPTY;
            sr_r    <= {IN_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (flush) begin
            state_r <= EMPTY;
            sr_r    <= {IN_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_xfer_s) begin
                        sr_r    <= in_data;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ACTIVE;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                ACTIVE: begin
                    if (out_xfer_s && final_beat_s) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (in_xfer_s) begin
                            sr_r    <= in_data;
                            state_r <= ACTIVE;
                        end else begin
                            sr_r    <= {IN_W{1'b0}};
                            state_r <= EMPTY;
                        end
                    end else begin
                        if (out_xfer_s) begin
                            sr_r  <= sr_shift_s;
                            cnt_r <= cnt_r + CNT_W'(1);
                        end else begin
                            sr_r  <= sr_r;
                        end
                        state_r <= in_xfer_s ? HELD : ACTIVE;
                    end
                end
                HELD: begin
                    if (out_xfer_s && final_beat_s) begin
                        sr_r    <= hb_data_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ACTIVE;
                    end else if (out_xfer_s) begin
                        sr_r    <= sr_shift_s;
                        cnt_r   <= cnt_r + CNT_W'(1);
                        state_r <= HELD;
                    end else begin
                        state_r <= HELD;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                    sr_r    <= {IN_W{1'b0}};
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flexbyte_pts_stream.sv
// Bench: MSB- and LSB-first 16/8 instances share stimulus and are checked every cycle
// against a word-queue model; a 32/4 instance covers the wide-ratio case.
module tb_flexbyte_pts_stream;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         flush, in_valid, out_ready;
    logic [127:0] in_data;
    logic         in_ready_a, out_valid_a, out_first_a, out_last_a;
    logic         in_ready_b, out_valid_b, out_first_b, out_last_b;
    logic [63:0]  out_data_a, out_data_b;

    logic         c_flush, c_in_valid, c_out_ready;
    logic [255:0] c_in_data;
    logic         c_in_ready, c_out_valid, c_out_first, c_out_last;
    logic [31:0]  c_out_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    flexbyte_pts_stream #(.NUM_BYTES_IN(16), .NUM_BYTES_OUT(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .n_rst(n_rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_first(out_first_a), .out_last(out_last_a));

    flexbyte_pts_stream #(.NUM_BYTES_IN(16), .NUM_BYTES_OUT(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .n_rst(n_rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_first(out_first_b), .out_last(out_last_b));

    flexbyte_pts_stream #(.NUM_BYTES_IN(32), .NUM_BYTES_OUT(4), .MSB_FIRST(1'b1)) dut_c (
        .clk(clk), .n_rst(n_rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_first(c_out_first), .out_last(c_out_last));

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: queue of accepted words not yet fully emitted; head beat index.
    logic [127:0] mq[$];
    int           midx = 0;
    logic         m_valid, m_ready, m_ox, m_ix;
    logic [127:0] mw;

    always @(negedge clk) begin
        if (!n_rst) begin
            mq.delete();
            midx = 0;
        end
        m_valid = (mq.size() > 0);
        m_ready = (mq.size() < 2) && !flush;
        chk("a_in_ready", in_ready_a, m_ready);
        chk("b_in_ready", in_ready_b, m_ready);
        chk("a_out_valid", out_valid_a, m_valid);
        chk("b_out_valid", out_valid_b, m_valid);
        if (m_valid) begin
            mw = mq[0];
            chk("a_out_data", out_data_a, mw[127 - 64*midx -: 64]);
            chk("b_out_data", out_data_b, mw[64*midx +: 64]);
            chk("a_first", out_first_a, midx == 0);
            chk("a_last", out_last_a, midx == 1);
            chk("b_first", out_first_b, midx == 0);
            chk("b_last", out_last_b, midx == 1);
        end else begin
            chk("a_first_idle", out_first_a, 1'b0);
            chk("a_last_idle", out_last_a, 1'b0);
            chk("b_last_idle", out_last_b, 1'b0);
        end
        if (n_rst) begin
            if (flush) begin
                mq.delete();
                midx = 0;
            end else begin
                m_ox = m_valid && out_ready;
                m_ix = in_valid && m_ready;
                if (m_ox) begin
                    midx++;
                    if (midx == 2) begin
                        void'(mq.pop_front());
                        midx = 0;
                    end
                end
                if (m_ix) mq.push_back(in_data);
            end
        end
    end

    localparam logic [127:0] W0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    initial begin
        logic [127:0] words [3];
        logic [255:0] c_word;
        logic [31:0]  c_exp;
        int acc, beats, first_v, last_v, saw_block;
        logic rdy;

        n_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 128'd0;
        c_flush = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_data = 256'd0;
        #2;
        chk("rst_out_valid", out_valid_a, 1'b0);
        chk("rst_out_data", out_data_a, 64'd0);
        chk("rst_first", out_first_a, 1'b0);
        chk("rst_in_ready", in_ready_a, 1'b1);
        repeat (3) tick();
        n_rst = 1'b1;
        tick();

        // Single word, both beat orders
        in_valid = 1'b1; in_data = W0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_beat0", out_data_a, 64'h0011223344556677);
        chk("t1_first0", out_first_a, 1'b1);
        chk("t1_last0", out_last_a, 1'b0);
        chk("t2_beat0", out_data_b, 64'h8899AABBCCDDEEFF);
        @(negedge clk);
        chk("t1_beat1", out_data_a, 64'h8899AABBCCDDEEFF);
        chk("t1_last1", out_last_a, 1'b1);
        chk("t2_beat1", out_data_b, 64'h0011223344556677);
        @(negedge clk);
        chk("t1_drained", out_valid_a, 1'b0);
        tick();

        // Three words back to back
        words[0] = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
        words[1] = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
        words[2] = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
        acc = 0; beats = 0; first_v = -1; last_v = -1; saw_block = 0;
        in_valid = 1'b1; in_data = words[0]; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid_a) begin
                beats++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            if (!in_ready_a) saw_block = 1;
            rdy = in_ready_a;
            tick();
            if (in_valid && rdy) begin
                acc++;
                if (acc == 3) in_valid = 1'b0;
                else in_data = words[acc];
            end
        end
        chk("t3_beats", beats, 6);
        chk("t3_no_gap", last_v - first_v + 1, 6);
        chk("t3_held_block", saw_block, 1);

        // Flush with HB full on the final beat
        in_valid = 1'b1; in_data = words[0]; out_ready = 1'b1;
        tick();
        in_data = words[1];
        tick();
        chk("t5_held_ready", in_ready_a, 1'b0);
        in_valid = 1'b0; flush = 1'b1;
        #1;
        chk("t5_flush_ready", in_ready_a, 1'b0);
        tick();
        flush = 1'b0;
        #1;
        chk("t5_after_valid", out_valid_a, 1'b0);
        chk("t5_after_ready", in_ready_a, 1'b1);
        in_valid = 1'b1; in_data = words[2];
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_restart_data", out_data_a, 64'hC0C1C2C3C4C5C6C7);
        chk("t5_restart_first", out_first_a, 1'b1);
        tick();
        tick();

        // Asynchronous reset mid-word
        in_valid = 1'b1; in_data = W0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_rst = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid_a, 1'b0);
        chk("t6_rst_data", out_data_a, 64'd0);
        chk("t6_rst_last", out_last_a, 1'b0);
        repeat (2) tick();
        n_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_no_residual", out_valid_a, 1'b0);
        end
        tick();

        // Wide ratio: 32-byte word into 4-byte beats
        for (int i = 0; i < 32; i++) c_word[255 - 8*i -: 8] = 8'(i);
        chk("c_in_ready", c_in_ready, 1'b1);
        c_in_valid = 1'b1; c_in_data = c_word; c_out_ready = 1'b1;
        tick();
        c_in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            c_exp = {8'(4*k), 8'(4*k + 1), 8'(4*k + 2), 8'(4*k + 3)};
            chk("c_valid", c_out_valid, 1'b1);
            chk("c_data", c_out_data, c_exp);
            chk("c_first", c_out_first, k == 0);
            chk("c_last", c_out_last, k == 7);
        end
        @(negedge clk);
        chk("c_drained", c_out_valid, 1'b0);
        tick();

        // Randomized traffic with backpressure and occasional flush
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 64) == 0;
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
